// File: rtl/perip_bus_ctrl.sv
// Peripheral bus controller: decodes the CPU peripheral address into four
// 64-byte slots, stretches each access by a per-region wait count, returns read data.
module perip_bus_ctrl #(
  parameter int unsigned WAIT_R0 = 0,
  parameter int unsigned WAIT_R1 = 1,
  parameter int unsigned WAIT_R2 = 2,
  parameter int unsigned WAIT_R3 = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_cpuAddr,
  input  logic [7:0]  i_cpuWrData,
  input  logic        i_cpuWrSig,
  input  logic        i_cpuRdSig,
  output logic [7:0]  o_cpuRdData,
  output logic        o_cpuReady,
  output logic        o_busErr,
  output logic [3:0]  o_peripSel,
  output logic [5:0]  o_peripAddr,
  output logic [7:0]  o_peripWrData,
  output logic        o_peripWrSig,
  output logic        o_peripRdSig,
  input  logic [31:0] i_peripRdData
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  r_region, w_region_nxt;
  logic [7:0]  r_cpuRdData, w_cpuRdData_nxt;
  logic        r_cpuReady, w_cpuReady_nxt;
  logic        r_busErr, w_busErr_nxt;
  logic [3:0]  r_peripSel, w_peripSel_nxt;
  logic [5:0]  r_peripAddr, w_peripAddr_nxt;
  logic [7:0]  r_peripWrData, w_peripWrData_nxt;
  logic        r_peripWrSig, w_peripWrSig_nxt;
  logic        r_peripRdSig, w_peripRdSig_nxt;
  logic [3:0]  w_wait;

  always_comb begin
    w_wait = 4'(WAIT_R0);
    case (i_cpuAddr[7:6])
      2'd0: w_wait = 4'(WAIT_R0);
      2'd1: w_wait = 4'(WAIT_R1);
      2'd2: w_wait = 4'(WAIT_R2);
      2'd3: w_wait = 4'(WAIT_R3);
      default: w_wait = 4'(WAIT_R0);
    endcase
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_region_nxt      = r_region;
    w_cpuRdData_nxt   = r_cpuRdData;
    w_cpuReady_nxt    = 1'b0;
    w_busErr_nxt      = 1'b0;
    w_peripSel_nxt    = r_peripSel;
    w_peripAddr_nxt   = r_peripAddr;
    w_peripWrData_nxt = r_peripWrData;
    w_peripWrSig_nxt  = r_peripWrSig;
    w_peripRdSig_nxt  = r_peripRdSig;
    case (r_state)
      S_IDLE: begin
        if (i_cpuRdSig && i_cpuWrSig) begin
          w_busErr_nxt   = 1'b1;
          w_cpuReady_nxt = 1'b1;
          w_state_nxt    = S_DONE;
        end else if (i_cpuRdSig || i_cpuWrSig) begin
          w_region_nxt      = i_cpuAddr[7:6];
          w_cnt_nxt         = w_wait;
          w_peripSel_nxt    = 4'b0001 << i_cpuAddr[7:6];
          w_peripAddr_nxt   = i_cpuAddr[5:0];
          w_peripWrData_nxt = i_cpuWrData;
          w_peripRdSig_nxt  = i_cpuRdSig;
          w_peripWrSig_nxt  = i_cpuWrSig;
          w_state_nxt       = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          // The read strobe doubles as the captured access kind.
          if (r_peripRdSig)
            w_cpuRdData_nxt = i_peripRdData[{r_region, 3'b000} +: 8];
          w_peripSel_nxt   = 4'b0000;
          w_peripRdSig_nxt = 1'b0;
          w_peripWrSig_nxt = 1'b0;
          w_cpuReady_nxt   = 1'b1;
          w_state_nxt      = S_DONE;
        end
      end
      S_DONE: begin
        if (!i_cpuRdSig && !i_cpuWrSig)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_region      <= 2'd0;
      r_cpuRdData   <= 8'h00;
      r_cpuReady    <= 1'b0;
      r_busErr      <= 1'b0;
      r_peripSel    <= 4'b0000;
      r_peripAddr   <= 6'd0;
      r_peripWrData <= 8'h00;
      r_peripWrSig  <= 1'b0;
      r_peripRdSig  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_region      <= w_region_nxt;
      r_cpuRdData   <= w_cpuRdData_nxt;
      r_cpuReady    <= w_cpuReady_nxt;
      r_busErr      <= w_busErr_nxt;
      r_peripSel    <= w_peripSel_nxt;
      r_peripAddr   <= w_peripAddr_nxt;
      r_peripWrData <= w_peripWrData_nxt;
      r_peripWrSig  <= w_peripWrSig_nxt;
      r_peripRdSig  <= w_peripRdSig_nxt;
    end
  end

  assign o_cpuRdData   = r_cpuRdData;
  assign o_cpuReady    = r_cpuReady;
  assign o_busErr      = r_busErr;
  assign o_peripSel    = r_peripSel;
  assign o_peripAddr   = r_peripAddr;
  assign o_peripWrData = r_peripWrData;
  assign o_peripWrSig  = r_peripWrSig;
  assign o_peripRdSig  = r_peripRdSig;

endmodule

// File: tb/tb_perip_bus_ctrl.sv
// Self-checking bench for perip_bus_ctrl: vector table, hand corner cases,
// and random transactions checked against a transaction-level model.
module tb_perip_bus_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_cpuAddr = 8'h00;
  logic [7:0]  i_cpuWrData = 8'h00;
  logic        i_cpuWrSig = 1'b0;
  logic        i_cpuRdSig = 1'b0;
  logic [31:0] i_peripRdData = 32'h0;
  logic [7:0]  o_cpuRdData;
  logic        o_cpuReady;
  logic        o_busErr;
  logic [3:0]  o_peripSel;
  logic [5:0]  o_peripAddr;
  logic [7:0]  o_peripWrData;
  logic        o_peripWrSig;
  logic        o_peripRdSig;

  int n_checks = 0;
  int n_err = 0;
  logic [7:0] m_rddata = 8'h00;
  int waits [4] = '{0, 1, 2, 3};

  perip_bus_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cpuAddr(i_cpuAddr), .i_cpuWrData(i_cpuWrData),
    .i_cpuWrSig(i_cpuWrSig), .i_cpuRdSig(i_cpuRdSig), .o_cpuRdData(o_cpuRdData),
    .o_cpuReady(o_cpuReady), .o_busErr(o_busErr), .o_peripSel(o_peripSel),
    .o_peripAddr(o_peripAddr), .o_peripWrData(o_peripWrData), .o_peripWrSig(o_peripWrSig),
    .o_peripRdSig(o_peripRdSig), .i_peripRdData(i_peripRdData)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [31:0] pdata;
    int          hold;
    logic [3:0]  e_sel;
    logic [5:0]  e_paddr;
    int          e_cyc;
    logic [7:0]  e_rd;
    logic        e_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_txn(input string name, input vec_t v);
    int strobe_cyc = 0;
    int ready_edge = -1;
    int bad_stable = 0;
    int extra = 0;
    logic [7:0] wd = v.wdata;
    i_cpuRdSig = v.rd;
    i_cpuWrSig = v.wr;
    i_cpuAddr = v.addr;
    i_cpuWrData = v.wdata;
    i_peripRdData = v.pdata;
    for (int n = 1; n <= 40 && ready_edge < 0; n++) begin
      step();
      i_cpuAddr = 8'($urandom);
      i_cpuWrData = 8'($urandom);
      if (o_peripRdSig || o_peripWrSig) begin
        strobe_cyc++;
        if (o_peripSel !== v.e_sel || o_peripAddr !== v.e_paddr ||
            o_peripRdSig !== v.rd || o_peripWrSig !== v.wr ||
            (v.wr && o_peripWrData !== wd))
          bad_stable++;
      end else if (o_peripSel !== 4'b0000) begin
        bad_stable++;
      end
      if (o_cpuReady) begin
        ready_edge = n;
        chk({name, ".busErr"}, o_busErr, v.e_err);
        chk({name, ".rdData"}, o_cpuRdData, v.e_rd);
      end else if (o_busErr) begin
        bad_stable++;
      end
    end
    chk({name, ".strobe_cycles"}, strobe_cyc, v.e_cyc);
    chk({name, ".ready_edge"}, ready_edge, v.e_cyc + 1);
    chk({name, ".sel_addr_stable"}, bad_stable, 0);
    for (int k = 0; k < v.hold; k++) begin
      step();
      i_cpuAddr = 8'($urandom);
      if (o_cpuReady || o_busErr || o_peripRdSig || o_peripWrSig || o_peripSel != 4'b0000)
        extra++;
    end
    i_cpuRdSig = 1'b0;
    i_cpuWrSig = 1'b0;
    step();
    if (o_cpuReady || o_busErr || o_peripRdSig || o_peripWrSig) extra++;
    chk({name, ".no_retrigger"}, extra, 0);
    chk({name, ".rdData_after"}, o_cpuRdData, v.e_rd);
  endtask

  function automatic vec_t model(input logic rd, input logic wr, input logic [7:0] addr,
                                 input logic [7:0] wdata, input logic [31:0] pdata, input int hold);
    vec_t v;
    int region = int'(addr[7:6]);
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.pdata = pdata; v.hold = hold;
    v.e_err = rd && wr;
    if (v.e_err) begin
      v.e_sel = 4'b0000; v.e_paddr = 6'd0; v.e_cyc = 0; v.e_rd = m_rddata;
    end else begin
      v.e_sel = 4'(1 << region);
      v.e_paddr = addr[5:0];
      v.e_cyc = waits[region] + 1;
      v.e_rd = rd ? pdata[8*region +: 8] : m_rddata;
    end
    return v;
  endfunction

  vec_t vecs [7];

  initial begin
    //           rd    wr    addr   wdata  pdata         hold sel      paddr  cyc rd     err
    vecs[0] = '{1'b1, 1'b0, 8'h05, 8'h00, 32'h112233A5, 0,  4'b0001, 6'h05, 1,  8'hA5, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h87, 8'h3C, 32'hFFFFFFFF, 1,  4'b0100, 6'h07, 3,  8'hA5, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'hC0, 8'h00, 32'h5A334455, 10, 4'b1000, 6'h00, 4,  8'h5A, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 8'h41, 8'h00, 32'h1234C378, 0,  4'b0010, 6'h01, 2,  8'hC3, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 8'h10, 8'h99, 32'hEEEEEEEE, 2,  4'b0000, 6'h00, 0,  8'hC3, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 8'h3F, 8'h81, 32'h00000000, 0,  4'b0001, 6'h3F, 1,  8'hC3, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 8'hBE, 8'h00, 32'h00E70000, 0,  4'b0100, 6'h3E, 3,  8'hE7, 1'b0};

    repeat (4) @(posedge i_clk);
    #1;
    chk("rst.rdData", o_cpuRdData, 8'h00);
    chk("rst.ready_err", {o_cpuReady, o_busErr}, 2'b00);
    chk("rst.sel", o_peripSel, 4'b0000);
    chk("rst.addr_wdata", {o_peripAddr, o_peripWrData}, 14'd0);
    chk("rst.strobes", {o_peripRdSig, o_peripWrSig}, 2'b00);
    i_rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), vecs[i]);
    m_rddata = 8'hE7;

    // Address change mid-access must not move select or offset.
    i_cpuAddr = 8'h40; i_cpuRdSig = 1'b1; i_peripRdData = 32'h0000_6B00;
    step();
    chk("addrchg.e0", {o_peripSel, o_peripAddr, o_peripRdSig}, {4'b0010, 6'h00, 1'b1});
    i_cpuAddr = 8'h80;
    step();
    chk("addrchg.e1", {o_peripSel, o_peripAddr, o_peripRdSig}, {4'b0010, 6'h00, 1'b1});
    step();
    chk("addrchg.ready", {o_cpuReady, o_cpuRdData, o_peripSel}, {1'b1, 8'h6B, 4'b0000});
    i_cpuRdSig = 1'b0;
    step();
    m_rddata = 8'h6B;

    // Reset during an access drops strobes without a clock edge.
    i_cpuAddr = 8'hC5; i_cpuRdSig = 1'b1;
    step();
    chk("rstmid.active", {o_peripSel, o_peripRdSig}, {4'b1000, 1'b1});
    step();
    #2 i_rst = 1'b1;
    #1;
    chk("rstmid.dropped", {o_peripSel, o_peripRdSig, o_cpuReady, o_cpuRdData}, 14'd0);
    repeat (2) begin
      step();
      chk("rstmid.no_ready", {o_cpuReady, o_busErr}, 2'b00);
    end
    i_cpuRdSig = 1'b0;
    i_rst = 1'b0;
    m_rddata = 8'h00;
    step();

    for (int t = 0; t < 40; t++) begin
      vec_t v;
      int kind = $urandom_range(0, 9);
      logic rd = (kind == 0) || (kind >= 5);
      logic wr = (kind <= 4);
      v = model(rd, wr, 8'($urandom), 8'($urandom), $urandom, $urandom_range(0, 3));
      run_txn($sformatf("rnd%0d", t), v);
      m_rddata = v.e_rd;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
